pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the MIPS fetch stage; next generation of the plain PC register.
- Holds the fetch PC and computes the next PC internally: sequential increment, branch/jump redirect with optional architectural delay slot, exception vectoring with EPC/branch-delay capture, and ERET return.
- Sits between the decode/control logic (redirect and exception requests) and instruction memory (fetch_ready handshake).

---
 rtl/pc_seq_if.sv | 31 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_seq_if: groups the fetch-stage control and status signals of the PC sequencer.
//   master modport: decode/control and fetch side. It drives the requests and reads the PC state.
//   slave  modport: pc_sequencer. It receives the requests and drives the PC state.
// Signals:
//   stall, fetch_ready, branch_req, branch_target, exc_req, eret_req   (master -> slave)
//   pc, pc_valid, epc, exc_bd, addr_err                                (slave -> master)
interface pc_seq_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             fetch_ready;
    logic             branch_req;
    logic [WIDTH-1:0] branch_target;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic [WIDTH-1:0] epc;
    logic             exc_bd;
    logic             addr_err;

    modport master (
        output stall, fetch_ready, branch_req, branch_target, exc_req, eret_req,
        input  pc, pc_valid, epc, exc_bd, addr_err
    );

    modport slave (
        input  stall, fetch_ready, branch_req, branch_target, exc_req, eret_req,
        output pc, pc_valid, epc, exc_bd, addr_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the fetch program counter for the MIPS fetch stage.
// Each cycle it selects the next PC from one of these sources:
//   - the sequential increment,
//   - a branch or jump redirect, with an optional delay slot,
//   - the exception vector, which also captures EPC and the branch-delay flag,
//   - an ERET return to EPC.
// Ports:
//   clk    clock. All state updates on the rising edge.
//   reset  synchronous, active-high reset.
//   bus    pc_seq_if.slave. It carries these signals:
//            inputs:  stall, fetch_ready, branch_req, branch_target, exc_req, eret_req
//            outputs: pc, pc_valid, epc, exc_bd, addr_err. All outputs are registered.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400020,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h80000180,
    parameter int               INCR         = 4,
    parameter bit               DELAY_SLOT   = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    pc_seq_if.slave   bus
);
    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    typedef enum logic {
        ST_SEQ,   // normal sequential fetch
        ST_SLOT   // redirect pending; pc addresses the delay slot
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             exc_bd_q, exc_bd_d;
    logic             addr_err_q, addr_err_d;

    logic             adv;
    logic [WIDTH-1:0] aligned_target;
    logic             misaligned;

    always_comb begin
        adv            = pc_valid_q & bus.fetch_ready & ~bus.stall;
        aligned_target = {bus.branch_target[WIDTH-1:2], 2'b00};
        misaligned     = |bus.branch_target[1:0];

        pc_d       = pc_q;
        state_d    = state_q;
        target_d   = target_q;
        epc_d      = epc_q;
        exc_bd_d   = exc_bd_q;
        addr_err_d = 1'b0;
        // pc_valid becomes 1 on the first edge out of reset and stays 1.
        pc_valid_d = 1'b1;

        if (pc_valid_q && bus.exc_req) begin
            // An exception ignores stall and fetch_ready. In the delay slot,
            // EPC points back at the branch so the branch is re-executed after return.
            if (state_q == ST_SLOT) begin
                epc_d    = pc_q - INCR_W;
                exc_bd_d = 1'b1;
            end else begin
                epc_d    = pc_q;
                exc_bd_d = 1'b0;
            end
            pc_d     = EXC_VECTOR;
            state_d  = ST_SEQ;
            target_d = '0;
        end else if (adv) begin
            if (bus.eret_req) begin
                pc_d     = epc_q;
                state_d  = ST_SEQ;
                target_d = '0;
            end else if (state_q == ST_SLOT) begin
                // A branch request in the delay slot is ignored here.
                pc_d    = target_q;
                state_d = ST_SEQ;
            end else if (bus.branch_req) begin
                addr_err_d = misaligned;
                if (DELAY_SLOT) begin
                    pc_d     = pc_q + INCR_W;
                    target_d = aligned_target;
                    state_d  = ST_SLOT;
                end else begin
                    pc_d = aligned_target;
                end
            end else begin
                pc_d = pc_q + INCR_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SEQ;
            pc_q       <= RESET_VECTOR;
            target_q   <= '0;
            epc_q      <= '0;
            pc_valid_q <= 1'b0;
            exc_bd_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            epc_q      <= epc_d;
            pc_valid_q <= pc_valid_d;
            exc_bd_q   <= exc_bd_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.epc      = epc_q;
    assign bus.exc_bd   = exc_bd_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of two pc_sequencer instances driven with the same stimulus.
//   u_ds1 uses DELAY_SLOT=1 and u_ds0 uses DELAY_SLOT=0.
// A reference model tracks both instances, and the outputs are compared against it on every falling edge.
// Hand-computed literal checks pin the expected PC sequence.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, fetch_ready, branch_req, exc_req, eret_req;
    logic [31:0] branch_target;
    int          checks = 0;
    int          errors = 0;
    bit          tb_done = 1'b0;

    pc_seq_if #(.WIDTH(32)) if1 ();
    pc_seq_if #(.WIDTH(32)) if0 ();

    assign if1.stall = stall;           assign if0.stall = stall;
    assign if1.fetch_ready = fetch_ready; assign if0.fetch_ready = fetch_ready;
    assign if1.branch_req = branch_req; assign if0.branch_req = branch_req;
    assign if1.branch_target = branch_target; assign if0.branch_target = branch_target;
    assign if1.exc_req = exc_req;       assign if0.exc_req = exc_req;
    assign if1.eret_req = eret_req;     assign if0.eret_req = eret_req;

    pc_sequencer #(.DELAY_SLOT(1'b1)) u_ds1 (.clk(clk), .reset(reset), .bus(if1.slave));
    pc_sequencer #(.DELAY_SLOT(1'b0)) u_ds0 (.clk(clk), .reset(reset), .bus(if0.slave));

    always #5 clk = ~clk;

    // Reference model. Index 0 tracks DELAY_SLOT=1 and index 1 tracks DELAY_SLOT=0.
    logic [31:0] m_pc [2];
    logic [31:0] m_epc [2];
    logic [31:0] m_tgt [2];
    logic        m_valid [2];
    logic        m_bd [2];
    logic        m_aerr [2];
    logic        m_pending [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_pc[d] = 32'h00400020; m_valid[d] = 0; m_epc[d] = 0; m_bd[d] = 0;
                m_aerr[d] = 0; m_pending[d] = 0; m_tgt[d] = 0;
            end else begin
                m_aerr[d] = 0;
                if (m_valid[d] && exc_req) begin
                    m_epc[d] = m_pending[d] ? m_pc[d] - 32'd4 : m_pc[d];
                    m_bd[d]  = m_pending[d];
                    m_pc[d]  = 32'h80000180;
                    m_pending[d] = 0;
                end else if (m_valid[d] && fetch_ready && !stall) begin
                    if (eret_req) begin
                        m_pc[d] = m_epc[d]; m_pending[d] = 0;
                    end else if (m_pending[d]) begin
                        m_pc[d] = m_tgt[d]; m_pending[d] = 0;
                    end else if (branch_req) begin
                        m_aerr[d] = (branch_target % 4) != 0;
                        if (d == 0) begin
                            m_tgt[d] = branch_target & ~32'd3;
                            m_pc[d] = m_pc[d] + 32'd4;
                            m_pending[d] = 1;
                        end else begin
                            m_pc[d] = branch_target & ~32'd3;
                        end
                    end else begin
                        m_pc[d] = m_pc[d] + 32'd4;
                    end
                end
                m_valid[d] = 1;
            end
        end
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!tb_done) begin
            cmp("m1.pc", if1.pc, m_pc[0]);
            cmp("m1.valid", 32'(if1.pc_valid), 32'(m_valid[0]));
            cmp("m1.epc", if1.epc, m_epc[0]);
            cmp("m1.bd", 32'(if1.exc_bd), 32'(m_bd[0]));
            cmp("m1.aerr", 32'(if1.addr_err), 32'(m_aerr[0]));
            cmp("m0.pc", if0.pc, m_pc[1]);
            cmp("m0.valid", 32'(if0.pc_valid), 32'(m_valid[1]));
            cmp("m0.epc", if0.epc, m_epc[1]);
            cmp("m0.bd", 32'(if0.exc_bd), 32'(m_bd[1]));
            cmp("m0.aerr", 32'(if0.addr_err), 32'(m_aerr[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b stl=%0b rdy=%0b br=%0b exc=%0b eret=%0b ds1.pc=%h ds0.pc=%h epc=%h bd=%0b aerr=%0b",
                 $time, reset, stall, fetch_ready, branch_req, exc_req, eret_req,
                 if1.pc, if0.pc, if1.epc, if1.exc_bd, if1.addr_err);
    endtask

    task automatic branch(logic [31:0] tgt);
        branch_req = 1; branch_target = tgt;
        step();
        branch_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish before t=100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; stall = 0; fetch_ready = 1; branch_req = 0; exc_req = 0; eret_req = 0;
        branch_target = 0;
        step(); step();
        cmp("rst.pc", if1.pc, 32'h00400020);
        cmp("rst.valid", 32'(if1.pc_valid), 0);
        cmp("rst.epc", if1.epc, 0);
        cmp("rst.bd", 32'(if1.exc_bd), 0);
        cmp("rst.aerr", 32'(if1.addr_err), 0);

        reset = 0; #1;
        cmp("rel.pc", if1.pc, 32'h00400020);
        cmp("rel.valid", 32'(if1.pc_valid), 0);
        step();
        cmp("first.valid", 32'(if1.pc_valid), 1);
        cmp("first.pc", if1.pc, 32'h00400020);
        step(); cmp("seq.pc1", if1.pc, 32'h00400024);
        step(); cmp("seq.pc2", if1.pc, 32'h00400028);

        // Delay slot versus immediate redirect.
        branch(32'h00400100);
        cmp("ds1.slot", if1.pc, 32'h0040002C);
        cmp("ds0.redir", if0.pc, 32'h00400100);

        // Stall, then not-ready, while in the slot.
        stall = 1;
        repeat (3) begin step(); cmp("stall.pc", if1.pc, 32'h0040002C); end
        stall = 0; fetch_ready = 0;
        repeat (2) begin step(); cmp("nrdy.pc", if1.pc, 32'h0040002C); end
        fetch_ready = 1;
        step(); cmp("slot.redir", if1.pc, 32'h00400100);
        step(); cmp("slot.after", if1.pc, 32'h00400104);

        // Exception in the slot, then ERET.
        branch(32'h00400028); cmp("b28.slot", if1.pc, 32'h00400108);
        step(); cmp("b28.tgt", if1.pc, 32'h00400028);
        branch(32'h00400100); cmp("b100.slot", if1.pc, 32'h0040002C);
        exc_req = 1; step(); exc_req = 0;
        cmp("exc.pc", if1.pc, 32'h80000180);
        cmp("exc.epc", if1.epc, 32'h00400028);
        cmp("exc.bd", 32'(if1.exc_bd), 1);
        eret_req = 1; step(); eret_req = 0;
        cmp("eret.pc", if1.pc, 32'h00400028);
        step(); cmp("eret.seq", if1.pc, 32'h0040002C);

        // All requests together under stall: the exception wins.
        stall = 1; exc_req = 1; eret_req = 1; branch_req = 1; branch_target = 32'h00400200;
        step();
        stall = 0; exc_req = 0; eret_req = 0; branch_req = 0;
        cmp("prio.pc", if1.pc, 32'h80000180);
        cmp("prio.epc", if1.epc, 32'h0040002C);
        cmp("prio.bd", 32'(if1.exc_bd), 0);
        step(); cmp("prio.next", if1.pc, 32'h80000184);

        // Misaligned target.
        branch(32'h00400102);
        cmp("mis.pc", if1.pc, 32'h80000188);
        cmp("mis.aerr", 32'(if1.addr_err), 1);
        cmp("mis.ds0pc", if0.pc, 32'h00400100);
        cmp("mis.ds0aerr", 32'(if0.addr_err), 1);
        step();
        cmp("mis.tgt", if1.pc, 32'h00400100);
        cmp("mis.pulse", 32'(if1.addr_err), 0);

        // Wrap-around.
        branch(32'hFFFFFFFC); cmp("wrap.slot", if1.pc, 32'h00400104);
        step(); cmp("wrap.top", if1.pc, 32'hFFFFFFFC);
        step(); cmp("wrap.zero", if1.pc, 32'h00000000);

        // Reset while in the slot.
        branch(32'h00400300); cmp("rs.slot", if1.pc, 32'h00000004);
        reset = 1; step();
        cmp("rs.pc", if1.pc, 32'h00400020);
        cmp("rs.valid", 32'(if1.pc_valid), 0);
        cmp("rs.epc", if1.epc, 0);
        reset = 0; step();
        cmp("rs.rel", if1.pc, 32'h00400020);
        step(); cmp("rs.seq", if1.pc, 32'h00400024);

        tb_done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
